// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
// Imported by the interface, the fetch module and the bench.
package if_fetch_pkg;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_e;

    localparam int          InstAddrBus   = 32;
    localparam int          InstBus       = 32;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    localparam logic [2:0]  BytesPerInst  = 3'd4;
    localparam logic [2:0]  LastByteIdx   = 3'd3;
    localparam logic [31:0] InstStride    = 32'd4;

    // Byte offset of the issue counter applied to the current PC.
    function automatic logic [InstAddrBus-1:0] byte_addr(
        input logic [InstAddrBus-1:0] base,
        input logic [2:0]             offset
    );
        return base + {29'd0, offset};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: byte memory port, IF/ID handshake and EX redirect.
// master = fetch stage, slave = memory/IF-ID/EX surroundings.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   mem_gnt_i;
    logic [7:0]             mem_din_i;
    logic [InstAddrBus-1:0] mem_a_o;
    logic                   mem_rd_o;
    logic                   stall_i;
    logic                   jump_i;
    logic [InstAddrBus-1:0] jump_addr_i;
    logic                   inst_valid_o;
    logic [InstAddrBus-1:0] pc_o;
    logic [InstBus-1:0]     inst_o;

    // Handshake: inst_valid_o=1 means {pc_o, inst_o} is a complete instruction;
    // it is consumed on a rising edge where stall_i=0 and jump_i=0, otherwise held.
    modport master (
        input  mem_gnt_i, mem_din_i, stall_i, jump_i, jump_addr_i,
        output mem_a_o, mem_rd_o, inst_valid_o, pc_o, inst_o
    );

    modport slave (
        output mem_gnt_i, mem_din_i, stall_i, jump_i, jump_addr_i,
        input  mem_a_o, mem_rd_o, inst_valid_o, pc_o, inst_o
    );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads,
// presents it to IF/ID with a valid/stall handshake and restarts on EX jumps.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus,
    output if_state_e  dbg_state_o
);

    logic [InstAddrBus-1:0] pc_q, pc_d;
    if_state_e              state_q, state_d;
    logic [2:0]             issue_cnt_q, issue_cnt_d;
    logic [2:0]             recv_cnt_q, recv_cnt_d;
    logic                   pending_q, pending_d;
    logic [3:0][7:0]        byte_q, byte_d;
    logic                   issue;

    // Reset gating keeps the memory port quiet while rst is held low.
    assign issue = rst && (state_q == IF_FETCH) && (issue_cnt_q < BytesPerInst)
                   && bus.mem_gnt_i && !bus.jump_i;

    assign bus.mem_rd_o     = issue;
    assign bus.mem_a_o      = issue ? byte_addr(pc_q, issue_cnt_q) : ZeroWord;
    assign bus.inst_valid_o = rst && (state_q == IF_HOLD) && !bus.jump_i;
    assign bus.pc_o         = pc_q;
    assign bus.inst_o       = byte_q;
    assign dbg_state_o      = state_q;

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        pending_d   = issue;
        byte_d      = byte_q;

        if (bus.jump_i) begin
            // The byte returning this cycle belongs to the abandoned stream.
            pc_d        = bus.jump_addr_i;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
            state_d     = IF_FETCH;
        end else if (state_q == IF_FETCH) begin
            if (issue) begin
                issue_cnt_d = issue_cnt_q + 3'd1;
            end
            if (pending_q) begin
                byte_d[recv_cnt_q[1:0]] = bus.mem_din_i;
                recv_cnt_d              = recv_cnt_q + 3'd1;
                if (recv_cnt_q == LastByteIdx) begin
                    state_d = IF_HOLD;
                end
            end
        end else if (!bus.stall_i) begin
            pc_d        = pc_q + InstStride;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
            state_d     = IF_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            state_q     <= IF_FETCH;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            pending_q   <= 1'b0;
            byte_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pending_q   <= pending_d;
            byte_q      <= byte_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table, hand-written jump/stall/reset
// sequences and a randomized run against a transaction-level fetch model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic      clk = 1'b0;
    logic      rst;
    if_state_e dbg_state;
    int        total = 0;
    int        bad   = 0;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- memory contents and responder ----------------
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] r;
        case (a)
            32'd0:   r = 8'h13;
            32'd1:   r = 8'h05;
            32'd2:   r = 8'h10;
            32'd3:   r = 8'h00;
            default: r = a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ a[31:24] ^ 8'h5C;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
                mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    logic        rd_s = 1'b0;
    logic [31:0] a_s  = 32'd0;

    always @(negedge clk) begin
        rd_s = bus.mem_rd_o;
        a_s  = bus.mem_a_o;
    end

    // Data returns the cycle after the address; otherwise the bus carries junk.
    always @(posedge clk) begin
        #1;
        bus.mem_din_i = rd_s ? mem_byte(a_s) : 8'($urandom);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic s, input logic j, input logic [31:0] ja);
        bus.mem_gnt_i   = g;
        bus.stall_i     = s;
        bus.jump_i      = j;
        bus.jump_addr_i = ja;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds reset with grant asserted, checks reset outputs, releases after an edge.
    task automatic apply_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rd",    32'(bus.mem_rd_o), 32'd0);
        chk("rst.addr",  bus.mem_a_o, 32'd0);
        chk("rst.valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst.pc",    bus.pc_o, RST_PC);
        chk("rst.inst",  bus.inst_o, 32'd0);
        next_cycle();
        rst = 1'b1;
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        gnt;
        logic        stall;
        logic        jump;
        logic [31:0] jaddr;
        logic        e_rd;
        logic [31:0] e_a;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic s, input logic e_rd,
                                input logic [31:0] e_a, input logic e_v,
                                input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.gnt = g;  v.stall = s;  v.jump = 1'b0;  v.jaddr = 32'd0;
        v.e_rd = e_rd;  v.e_a = e_a;  v.e_v = e_v;  v.e_pc = e_pc;  v.e_inst = e_inst;
        return v;
    endfunction

    vec_t tbl[17];

    // ---------------- randomized model state ----------------
    logic [63:0] exp_q[$];

    initial begin
        logic [31:0] w4;
        logic [31:0] exp_pc;
        logic [31:0] ja;
        logic        g, s, j, hold, exp_rd, exp_v;
        int          k, t4;

        rst = 1'b0;
        w4  = mem_word(32'd4);
        // Cycle-by-cycle from reset release: fetch @0, fetch @4 with a grant gap,
        // then three stalled HOLD cycles before the instruction is consumed.
        tbl[0]  = mk(1, 0, 1, 32'd0, 0, 32'd0, 32'd0);
        tbl[1]  = mk(1, 0, 1, 32'd1, 0, 32'd0, 32'd0);
        tbl[2]  = mk(1, 0, 1, 32'd2, 0, 32'd0, 32'd0);
        tbl[3]  = mk(1, 0, 1, 32'd3, 0, 32'd0, 32'd0);
        tbl[4]  = mk(1, 0, 0, 32'd0, 0, 32'd0, 32'd0);
        tbl[5]  = mk(1, 0, 0, 32'd0, 1, 32'd0, 32'h0010_0513);
        tbl[6]  = mk(1, 0, 1, 32'd4, 0, 32'd4, 32'd0);
        tbl[7]  = mk(1, 0, 1, 32'd5, 0, 32'd4, 32'd0);
        tbl[8]  = mk(0, 0, 0, 32'd0, 0, 32'd4, 32'd0);
        tbl[9]  = mk(1, 0, 1, 32'd6, 0, 32'd4, 32'd0);
        tbl[10] = mk(1, 0, 1, 32'd7, 0, 32'd4, 32'd0);
        tbl[11] = mk(1, 0, 0, 32'd0, 0, 32'd4, 32'd0);
        tbl[12] = mk(1, 1, 0, 32'd0, 1, 32'd4, w4);
        tbl[13] = mk(1, 1, 0, 32'd0, 1, 32'd4, w4);
        tbl[14] = mk(1, 1, 0, 32'd0, 1, 32'd4, w4);
        tbl[15] = mk(1, 0, 0, 32'd0, 1, 32'd4, w4);
        tbl[16] = mk(1, 0, 1, 32'd8, 0, 32'd8, 32'd0);

        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].gnt, tbl[i].stall, tbl[i].jump, tbl[i].jaddr);
            @(negedge clk);
            chk($sformatf("t%0d.rd", i),    32'(bus.mem_rd_o), 32'(tbl[i].e_rd));
            chk($sformatf("t%0d.addr", i),  bus.mem_a_o, tbl[i].e_a);
            chk($sformatf("t%0d.valid", i), 32'(bus.inst_valid_o), 32'(tbl[i].e_v));
            chk($sformatf("t%0d.pc", i),    bus.pc_o, tbl[i].e_pc);
            if (tbl[i].e_v) chk($sformatf("t%0d.inst", i), bus.inst_o, tbl[i].e_inst);
            next_cycle();
        end

        // Jump in the cycle after byte2 issue: returning byte2 must be dropped.
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, c == 3, 32'h0000_0100);
            @(negedge clk);
            if (c < 3) begin
                chk($sformatf("jf%0d.addr", c), bus.mem_a_o, 32'(c));
            end else if (c == 3) begin
                chk("jf3.rd", 32'(bus.mem_rd_o), 32'd0);
                chk("jf3.valid", 32'(bus.inst_valid_o), 32'd0);
            end else if (c < 8) begin
                chk($sformatf("jf%0d.rd", c), 32'(bus.mem_rd_o), 32'd1);
                chk($sformatf("jf%0d.addr", c), bus.mem_a_o, 32'h100 + 32'(c - 4));
                chk($sformatf("jf%0d.pc", c), bus.pc_o, 32'h100);
            end else if (c == 9) begin
                chk("jf9.valid", 32'(bus.inst_valid_o), 32'd1);
                chk("jf9.pc", bus.pc_o, 32'h100);
                chk("jf9.inst", bus.inst_o, mem_word(32'h100));
            end
            next_cycle();
        end

        // Jump together with stall while holding an instruction.
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, c >= 5 && c <= 6, c == 6, 32'h0000_0200);
            @(negedge clk);
            if (c == 5) chk("js5.valid", 32'(bus.inst_valid_o), 32'd1);
            if (c == 6) begin
                chk("js6.valid", 32'(bus.inst_valid_o), 32'd0);
                chk("js6.rd", 32'(bus.mem_rd_o), 32'd0);
            end
            if (c == 7) begin
                chk("js7.addr", bus.mem_a_o, 32'h200);
                chk("js7.pc", bus.pc_o, 32'h200);
            end
            next_cycle();
        end

        // Asynchronous reset with a read outstanding, then a clean restart.
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            if (c == 2) chk("ar.inst_pre", bus.inst_o, 32'h0000_0013);
            if (c < 2) next_cycle();
        end
        #1 rst = 1'b0;
        #1;
        chk("ar.rd", 32'(bus.mem_rd_o), 32'd0);
        chk("ar.addr", bus.mem_a_o, 32'd0);
        chk("ar.valid", 32'(bus.inst_valid_o), 32'd0);
        chk("ar.pc", bus.pc_o, RST_PC);
        chk("ar.inst", bus.inst_o, 32'd0);
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) chk("ar.restart_addr", bus.mem_a_o, RST_PC);
            if (c == 5) chk("ar.restart_inst", bus.inst_o, 32'h0010_0513);
            next_cycle();
        end

        // Randomized run: instruction stream follows pc+4 / jump targets, each
        // instruction needs four granted issues and is presented two cycles later.
        apply_reset();
        exp_pc = RST_PC;
        k      = 0;
        t4     = 0;
        exp_q.delete();
        exp_q.push_back({exp_pc, mem_word(exp_pc)});
        for (int cyc = 0; cyc < 3000; cyc++) begin
            g = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       ja = 32'($urandom_range(0, 255));
                1:       ja = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2:       ja = $urandom;
                default: ja = 32'h0000_0100;
            endcase
            drive(g, s, j, ja);
            @(negedge clk);
            hold   = (k == 4) && (cyc >= t4 + 2);
            exp_rd = !j && !hold && (k < 4) && g;
            exp_v  = hold && !j;
            chk("rnd.rd", 32'(bus.mem_rd_o), 32'(exp_rd));
            chk("rnd.addr", bus.mem_a_o, exp_rd ? exp_pc + 32'(k) : 32'd0);
            chk("rnd.valid", 32'(bus.inst_valid_o), 32'(exp_v));
            if (exp_v) begin
                if (exp_q.size() == 0) begin
                    chk("rnd.queue", 32'd0, 32'd1);
                end else begin
                    chk("rnd.pc", bus.pc_o, exp_q[0][63:32]);
                    chk("rnd.inst", bus.inst_o, exp_q[0][31:0]);
                end
            end
            if (j) begin
                exp_pc = ja;
                k      = 0;
                exp_q.delete();
                exp_q.push_back({exp_pc, mem_word(exp_pc)});
            end else if (hold) begin
                if (!s) begin
                    exp_pc = exp_pc + 32'd4;
                    k      = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    exp_q.push_back({exp_pc, mem_word(exp_pc)});
                end
            end else if (exp_rd) begin
                k++;
                if (k == 4) t4 = cyc;
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage directly upstream of the decode stage. It owns the PC and reads each 32-bit instruction from the unified 8-bit memory port as four byte reads. It presents a completed {pc, inst} pair to the IF/ID register with a valid/stall handshake, and restarts on a taken jump/branch from EX.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, reset; asynchronous, active-low.
- mem_gnt_i, input, 1, memory port granted to fetch this cycle.
- mem_din_i, input, 8, read byte; returns the cycle after its address was issued.
- mem_a_o, output, 32, byte address to memory.
- mem_rd_o, output, 1, read request this cycle.
- stall_i, input, 1, IF/ID cannot accept; hold the presented instruction.
- jump_i, input, 1, taken jump/branch from EX; redirect fetch.
- jump_addr_i, input, 32, redirect target.
- inst_valid_o, output, 1, pc_o/inst_o hold a complete instruction.
- pc_o, output, 32, PC of the presented instruction.
- inst_o, output, 32, instruction, little-endian {b3,b2,b1,b0}.

## Operation
- Registers: pc (32), state {FETCH, HOLD}, issue_cnt (0..4), recv_cnt (0..4), pending (1), byte buffer b0..b3.
- Reset (rst low, async): pc=RESET_PC, state=FETCH, counters=0, pending=0, buffer=0. While rst is low: mem_rd_o=0, mem_a_o=0, inst_valid_o=0, pc_o=RESET_PC, inst_o=0.
- FETCH, issue: if issue_cnt<4 && mem_gnt_i && !jump_i, then mem_rd_o=1, mem_a_o=pc+issue_cnt, issue_cnt++, pending<=1. Otherwise mem_rd_o=0, mem_a_o=0, pending<=0.
- FETCH, receive: if pending, b[recv_cnt]<=mem_din_i and recv_cnt++. When recv_cnt becomes 4, state<=HOLD.
- Issue and receive proceed in the same cycle. Grant loss only pauses issue; a byte already issued is still captured.
- HOLD: inst_valid_o = !jump_i. If !stall_i && !jump_i: pc<=pc+4, counters<=0, state<=FETCH. If stall_i: everything holds and no memory request is made.
- Jump (any state, highest priority over stall and grant): pc<=jump_addr_i, counters<=0, pending<=0, state<=FETCH. No request is issued in the jump cycle. Any byte returning in the next cycle is discarded because pending=0.
- Addresses: 32-bit wrap-around on pc+issue_cnt and pc+4. There is no alignment check, since byte fetch tolerates any address.
- pc_o=pc and inst_o={b3,b2,b1,b0} are driven continuously. They are meaningful only when inst_valid_o=1.

## Timing
- Continuous grant, no stall: byte addresses are issued in cycles 0..3, byte k is captured at the end of cycle k+1, inst_valid_o=1 in cycle 5, and the next byte0 is issued in cycle 6. Throughput is 6 cycles/instruction.
- Each grant-denied cycle during issue adds one cycle of latency.
- Stall: inst_valid_o, pc_o and inst_o stay stable for every stalled cycle. The instruction is consumed on the first edge with stall_i=0.
- Jump to first request at the new target: 1 cycle.
- inst_valid_o, mem_rd_o and mem_a_o are combinational from registers plus jump_i/mem_gnt_i. There is no other input-to-output path.

## Structure
- Add to defines.v: fetch state encodings (IF_FETCH, IF_HOLD). Reuse InstAddrBus, InstBus and ZeroWord from defines.v.
- Single module with no sub-module; the byte buffer and counters are small enough to inline.
- Top level: inst_valid_o gates the IF/ID register; jump_i comes from the EX branch unit; mem_gnt_i comes from the memory arbiter, which gives MEM-stage accesses priority.

## Test plan
- Reset then fetch, with memory bytes 0x13,0x05,0x10,0x00 at 0..3 and grant held high → addresses 0,1,2,3 in cycles 0–3; cycle 5 shows inst_valid_o=1, pc_o=0, inst_o=32'h00100513; byte0 at address 4 is issued in cycle 6.
- Grant dropped during the cycle after issue of byte1 → byte1 is still captured, address 2 is issued one cycle late, and inst_valid_o arrives in cycle 6.
- Hold with stall_i=1 for 3 cycles in HOLD → outputs stable and mem_rd_o=0 throughout; pc becomes 4 on the edge after stall_i falls.
- Raise jump_i with jump_addr_i=32'h0000_0100 in the cycle after the byte2 issue → the returning byte is dropped; the next cycle issues address 0x100; the presented pc_o is 0x100.
- Raise jump_i together with stall_i in HOLD → inst_valid_o=0 that cycle, and the fetch restarts at the target.
- Assert rst mid-fetch (pending=1) → all outputs go to reset values immediately; after release, fetch restarts at RESET_PC.
